// File: rtl/seg_scan_capture.sv
// Decodes a multiplexed active-low anode/segment display bus back into hex nibbles.
// One nibble is captured per digit dwell; a valid strobe fires once per complete scan frame.
module seg_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_DIGITS-1:0]   an_in,
  input  logic [6:0]              seg_in,
  output logic [4*NUM_DIGITS-1:0] o_data,
  output logic                    o_valid,
  output logic [NUM_DIGITS-1:0]   o_blank,
  output logic [NUM_DIGITS-1:0]   o_digit_err,
  output logic                    o_frame_err
);

  localparam int         IDX_W    = $clog2(NUM_DIGITS);
  localparam logic [7:0] SETTLE_C = 8'(SETTLE_CYCLES);

  typedef enum logic [1:0] {IDLE, SETTLE, HELD} state_t;

  state_t                  state_reg, state_next;
  logic [7:0]              cnt_reg, cnt_next;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic [3:0]              zero_cnt;
  logic [IDX_W-1:0]        digit_idx;
  logic                    is_one_hot, is_multi, changed;
  logic [3:0]              dec_nib;
  logic                    dec_blank, dec_err;
  logic                    sample, restart;
  logic [NUM_DIGITS-1:0]   mask_reg, mask_next;
  logic                    frame_complete;
  logic                    ferr_stage_reg;
  logic [4*NUM_DIGITS-1:0] nib_stage;
  logic [NUM_DIGITS-1:0]   blank_stage, err_stage;

  // an_d/seg_d hold the previous cycle's registered bus for change detection
  always_ff @(posedge clk) begin
    if (rst) begin
      an_q  <= '1;
      an_d  <= '1;
      seg_q <= '1;
      seg_d <= '1;
    end else begin
      an_q  <= an_in;
      an_d  <= an_q;
      seg_q <= seg_in;
      seg_d <= seg_q;
    end
  end

  always_comb begin
    zero_cnt  = '0;
    digit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (!an_q[i]) begin
        zero_cnt  = zero_cnt + 4'd1;
        digit_idx = IDX_W'(i);
      end
    end
  end

  assign is_one_hot = (zero_cnt == 4'd1);
  assign is_multi   = (zero_cnt >= 4'd2);
  assign changed    = ({an_q, seg_q} != {an_d, seg_d});

  always_comb begin
    dec_nib   = 4'h0;
    dec_blank = 1'b0;
    dec_err   = 1'b0;
    case (seg_q)
      7'b1000000: dec_nib = 4'h0;
      7'b1111001: dec_nib = 4'h1;
      7'b0100100: dec_nib = 4'h2;
      7'b0110000: dec_nib = 4'h3;
      7'b0011001: dec_nib = 4'h4;
      7'b0010010: dec_nib = 4'h5;
      7'b0000010: dec_nib = 4'h6;
      7'b1111000: dec_nib = 4'h7;
      7'b0000000: dec_nib = 4'h8;
      7'b0011000: dec_nib = 4'h9;
      7'b0001000: dec_nib = 4'hA;
      7'b0000011: dec_nib = 4'hB;
      7'b1000110: dec_nib = 4'hC;
      7'b0100001: dec_nib = 4'hD;
      7'b0000110: dec_nib = 4'hE;
      7'b0001110: dec_nib = 4'hF;
      7'b1111111: dec_blank = 1'b1;
      default:    dec_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    sample     = 1'b0;
    restart    = 1'b0;
    case (state_reg)
      IDLE: restart = is_one_hot;
      SETTLE: begin
        if (changed) begin
          if (is_one_hot) begin
            restart = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
          if (cnt_next >= SETTLE_C) begin
            sample     = 1'b1;
            state_next = HELD;
          end
        end
      end
      HELD: begin
        if (changed) begin
          if (is_one_hot) begin
            restart = 1'b1;
          end else begin
            state_next = IDLE;
            cnt_next   = '0;
          end
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
    // A fresh one-hot value counts as its first stable cycle
    if (restart) begin
      cnt_next = 8'd1;
      if (SETTLE_C <= 8'd1) begin
        sample     = 1'b1;
        state_next = HELD;
      end else begin
        state_next = SETTLE;
      end
    end
  end

  assign frame_complete = &mask_reg;

  // A sample coinciding with completion lands in the freshly cleared mask
  always_comb begin
    mask_next = frame_complete ? '0 : mask_reg;
    if (sample) mask_next[digit_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mask_reg       <= '0;
      ferr_stage_reg <= 1'b0;
    end else begin
      mask_reg       <= mask_next;
      ferr_stage_reg <= (frame_complete ? 1'b0 : ferr_stage_reg) | is_multi;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_slot
      logic [3:0] nib_reg;
      logic       blank_reg, err_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          nib_reg   <= '0;
          blank_reg <= 1'b0;
          err_reg   <= 1'b0;
        end else if (sample && (digit_idx == IDX_W'(gi))) begin
          nib_reg   <= dec_nib;
          blank_reg <= dec_blank;
          err_reg   <= dec_err;
        end
      end
      assign nib_stage[4*gi +: 4] = nib_reg;
      assign blank_stage[gi]      = blank_reg;
      assign err_stage[gi]        = err_reg;
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      o_valid     <= 1'b0;
      o_data      <= '0;
      o_blank     <= '0;
      o_digit_err <= '0;
      o_frame_err <= 1'b0;
    end else begin
      o_valid <= frame_complete;
      if (frame_complete) begin
        o_data      <= nib_stage;
        o_blank     <= blank_stage;
        o_digit_err <= err_stage;
        o_frame_err <= ferr_stage_reg;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_capture.sv
// Bench for seg_scan_capture: table-driven frames, corner sequences and random traffic
// checked against a run-length reference model on two instances (settle 4 and settle 1).
module tb_seg_scan_capture;

  localparam logic [6:0] P1 = 7'b1111001, P2 = 7'b0100100, P3 = 7'b0110000, P4 = 7'b0011001;
  localparam logic [6:0] P5 = 7'b0010010, P6 = 7'b0000010, P7 = 7'b1111000, P8 = 7'b0000000;
  localparam logic [6:0] PA = 7'b0001000, PB = 7'b0000011, PC = 7'b1000110, PD = 7'b0100001;
  localparam logic [6:0] PF = 7'b0001110, PBL = 7'b1111111, PBAD = 7'b1010101;

  logic        clk, rst;
  logic [3:0]  an_in;
  logic [6:0]  seg_in;
  logic [15:0] o_data0, o_data1;
  logic        o_valid0, o_valid1, o_frame_err0, o_frame_err1;
  logic [3:0]  o_blank0, o_blank1, o_digit_err0, o_digit_err1;

  seg_scan_capture #(.NUM_DIGITS(4), .SETTLE_CYCLES(4)) u_dut (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .o_data(o_data0), .o_valid(o_valid0), .o_blank(o_blank0),
    .o_digit_err(o_digit_err0), .o_frame_err(o_frame_err0));

  seg_scan_capture #(.NUM_DIGITS(4), .SETTLE_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .an_in(an_in), .seg_in(seg_in),
    .o_data(o_data1), .o_valid(o_valid1), .o_blank(o_blank1),
    .o_digit_err(o_digit_err1), .o_frame_err(o_frame_err1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int vcount, vcyc, start_cyc;
  logic [15:0] cap_data;
  logic [3:0]  cap_blank, cap_err;
  logic        cap_ferr;
  logic [6:0]  seg_tab [16];

  // Reference model state, one slot per instance
  logic [10:0] m_prev [2];
  int          m_run [2];
  logic [3:0]  m_mask [2];
  logic [15:0] m_nib [2];
  logic [3:0]  m_blank [2], m_err [2];
  logic        m_ferr [2];
  int          pend_cyc [2];
  logic [15:0] pend_data [2], rep_data [2];
  logic [3:0]  pend_blank [2], pend_err [2], rep_blank [2], rep_err [2];
  logic        pend_ferr [2], rep_ferr [2];

  typedef struct {
    logic [27:0] segs;   // {d3,d2,d1,d0}
    logic        pre_multi;
    logic [15:0] data;
    logic [3:0]  blank;
    logic [3:0]  err;
    logic        ferr;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  // A digit is captured when a one-hot value has been presented for exactly S
  // consecutive cycles; the frame strobe appears two edges after that input edge.
  task automatic model_input(input int k, input logic [3:0] an, input logic [6:0] seg,
                             input logic r, input int e);
    int s, zeros, d;
    logic [3:0] nib;
    logic bl, er;
    s = (k == 0) ? 4 : 1;
    if (r) begin
      m_prev[k] = '1; m_run[k] = 0; m_mask[k] = '0; m_nib[k] = '0;
      m_blank[k] = '0; m_err[k] = '0; m_ferr[k] = 1'b0; pend_cyc[k] = -1;
      rep_data[k] = '0; rep_blank[k] = '0; rep_err[k] = '0; rep_ferr[k] = 1'b0;
      return;
    end
    zeros = 0; d = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) begin zeros++; d = i; end
    if (zeros >= 2) m_ferr[k] = 1'b1;
    if ({an, seg} == m_prev[k]) m_run[k]++; else m_run[k] = 1;
    m_prev[k] = {an, seg};
    if (zeros == 1 && m_run[k] == s) begin
      nib = 4'h0; bl = 1'b0; er = 1'b1;
      if (seg == PBL) begin bl = 1'b1; er = 1'b0; end
      else for (int v = 0; v < 16; v++) if (seg_tab[v] == seg) begin nib = 4'(v); er = 1'b0; end
      m_nib[k][4*d +: 4] = nib;
      m_blank[k][d] = bl;
      m_err[k][d] = er;
      m_mask[k][d] = 1'b1;
      if (m_mask[k] == 4'hF) begin
        pend_cyc[k] = e + 2;
        pend_data[k] = m_nib[k]; pend_blank[k] = m_blank[k];
        pend_err[k] = m_err[k]; pend_ferr[k] = m_ferr[k];
        m_mask[k] = '0; m_ferr[k] = 1'b0;
      end
    end
  endtask

  task automatic model_check(input int k);
    logic v, exp_v, f;
    logic [15:0] d;
    logic [3:0] b, er;
    if (k == 0) begin v = o_valid0; d = o_data0; b = o_blank0; er = o_digit_err0; f = o_frame_err0; end
    else        begin v = o_valid1; d = o_data1; b = o_blank1; er = o_digit_err1; f = o_frame_err1; end
    exp_v = 1'b0;
    if (pend_cyc[k] == cyc) begin
      exp_v = 1'b1;
      rep_data[k] = pend_data[k]; rep_blank[k] = pend_blank[k];
      rep_err[k] = pend_err[k]; rep_ferr[k] = pend_ferr[k];
      pend_cyc[k] = -1;
    end
    check($sformatf("model_valid%0d", k), 32'(v), 32'(exp_v));
    check($sformatf("model_data%0d", k), 32'(d), 32'(rep_data[k]));
    check($sformatf("model_blank%0d", k), 32'(b), 32'(rep_blank[k]));
    check($sformatf("model_derr%0d", k), 32'(er), 32'(rep_err[k]));
    check($sformatf("model_ferr%0d", k), 32'(f), 32'(rep_ferr[k]));
  endtask

  task automatic step(input logic [3:0] an, input logic [6:0] seg, input logic r);
    an_in = an; seg_in = seg; rst = r;
    model_input(0, an, seg, r, cyc + 1);
    model_input(1, an, seg, r, cyc + 1);
    @(posedge clk);
    cyc++;
    #1;
    model_check(0);
    model_check(1);
    if (o_valid0) begin
      vcount++; vcyc = cyc;
      cap_data = o_data0; cap_blank = o_blank0; cap_err = o_digit_err0; cap_ferr = o_frame_err0;
    end
  endtask

  // Scan digits 3..0 with 8-cycle dwells; optional glitch pattern leads digit 0's dwell
  task automatic scan(input logic [27:0] segs, input logic [6:0] glitch_seg, input int glitch_len);
    logic [3:0] a;
    for (int d = 3; d >= 1; d--) begin
      a = 4'b1111; a[d] = 1'b0;
      repeat (8) step(a, segs[7*d +: 7], 1'b0);
    end
    start_cyc = cyc;
    if (glitch_len > 0) begin
      repeat (glitch_len) step(4'b1110, glitch_seg, 1'b0);
      repeat (7) step(4'b1110, segs[6:0], 1'b0);
    end else begin
      repeat (8) step(4'b1110, segs[6:0], 1'b0);
    end
  endtask

  initial begin
    logic [3:0] a;
    logic [6:0] sg;
    int len, p, i0, j0;
    seg_tab = '{7'b1000000, P1, P2, P3, P4, P5, P6, P7, P8, 7'b0011000, PA, PB, PC, PD, 7'b0000110, PF};
    vecs[0] = '{{P1, P2, P3, P4},    1'b0, 16'h1234, 4'b0000, 4'b0000, 1'b0};
    vecs[1] = '{{P1, PBL, P2, PF},   1'b0, 16'h102F, 4'b0100, 4'b0000, 1'b0};
    vecs[2] = '{{P1, P2, PBAD, P4},  1'b0, 16'h1204, 4'b0000, 4'b0010, 1'b0};
    vecs[3] = '{{P1, P2, P3, P4},    1'b1, 16'h1234, 4'b0000, 4'b0000, 1'b1};
    vecs[4] = '{{P1, P2, P3, P4},    1'b0, 16'h1234, 4'b0000, 4'b0000, 1'b0};
    vecs[5] = '{{PA, PB, PC, PD},    1'b0, 16'hABCD, 4'b0000, 4'b0000, 1'b0};
    vecs[6] = '{{P5, P6, P7, P8},    1'b0, 16'h5678, 4'b0000, 4'b0000, 1'b0};
    an_in = '1; seg_in = '1; rst = 1'b1;
    vcount = 0; vcyc = 0; start_cyc = 0;
    cap_data = '0; cap_blank = '0; cap_err = '0; cap_ferr = 1'b0;

    repeat (3) step(4'hF, PBL, 1'b1);
    check("reset_valid", 32'(o_valid0), 32'd0);
    check("reset_data", 32'(o_data0), 32'd0);
    repeat (2) step(4'hF, PBL, 1'b0);

    for (int i = 0; i < 7; i++) begin
      vcount = 0;
      if (vecs[i].pre_multi) repeat (3) step(4'b1001, P8, 1'b0);
      scan(vecs[i].segs, PBL, 0);
      check($sformatf("vec%0d_count", i), 32'(vcount), 32'd1);
      check($sformatf("vec%0d_data", i), 32'(cap_data), 32'(vecs[i].data));
      check($sformatf("vec%0d_blank", i), 32'(cap_blank), 32'(vecs[i].blank));
      check($sformatf("vec%0d_derr", i), 32'(cap_err), 32'(vecs[i].err));
      check($sformatf("vec%0d_ferr", i), 32'(cap_ferr), 32'(vecs[i].ferr));
      check($sformatf("vec%0d_latency", i), 32'(vcyc - start_cyc), 32'd6);
    end

    // Glitch on the last digit: only the later pattern is captured, strobe 2 cycles later
    vcount = 0;
    scan({P1, P2, P3, PF}, P4, 2);
    check("glitch_count", 32'(vcount), 32'd1);
    check("glitch_data", 32'(cap_data), 32'h123F);
    check("glitch_latency", 32'(vcyc - start_cyc), 32'd8);

    // Reset with two digits captured: only the post-reset frame may report
    vcount = 0;
    repeat (8) step(4'b0111, P1, 1'b0);
    repeat (8) step(4'b1011, P2, 1'b0);
    repeat (2) step(4'b1101, P3, 1'b0);
    repeat (2) step(4'hF, PBL, 1'b1);
    check("midrst_data", 32'(o_data0), 32'd0);
    repeat (2) step(4'hF, PBL, 1'b0);
    scan({P5, P6, P7, P8}, PBL, 0);
    check("midrst_count", 32'(vcount), 32'd1);
    check("midrst_data_after", 32'(cap_data), 32'h5678);

    // Random traffic: gaps, multi-hot, bad patterns, short dwells, rare resets
    for (int n = 0; n < 400; n++) begin
      p = $urandom_range(0, 9);
      a = 4'b1111;
      i0 = $urandom_range(0, 3);
      if (p == 0) begin
        a = 4'b1111;
      end else if (p == 1) begin
        j0 = (i0 + $urandom_range(1, 3)) % 4;
        a[i0] = 1'b0; a[j0] = 1'b0;
      end else begin
        a[i0] = 1'b0;
      end
      p = $urandom_range(0, 19);
      if (p < 16) sg = seg_tab[p];
      else if (p == 16) sg = PBL;
      else sg = 7'($urandom);
      len = $urandom_range(1, 8);
      if ($urandom_range(0, 99) == 0) step(4'hF, PBL, 1'b1);
      repeat (len) step(a, sg, 1'b0);
    end
    repeat (4) step(4'hF, PBL, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
